// File: rtl/router_pkg.sv
// Shared constants, soft-reset mode enum and one-hot helper for the router synchroniser.
package router_pkg;
  localparam int NUM_CH_DEF  = 3;
  localparam int ADDR_W_DEF  = 2;
  localparam int TIMEOUT_DEF = 30;
  localparam int MAX_CH      = 16;
  localparam int MAX_ADDR_W  = 4;

  typedef enum logic {SR_PULSE = 1'b0, SR_LEVEL = 1'b1} sr_mode_e;

  // Callers size-cast the result down to their own channel count.
  function automatic logic [MAX_CH-1:0] onehot(input logic [MAX_ADDR_W-1:0] addr, input logic en);
    logic [MAX_CH-1:0] v;
    v       = '0;
    v[addr] = en;
    return v;
  endfunction
endpackage

// File: rtl/router_sync_timer.sv
// Per-channel read-timeout timer: soft-resets a FIFO whose reader leaves valid data untouched.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int       TIMEOUT = TIMEOUT_DEF,
  parameter int       TIMER_W = 5,
  parameter sr_mode_e SR_MODE = SR_PULSE
) (
  input  logic clk,
  input  logic reset,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);
  localparam logic [TIMER_W-1:0] LP_TC = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] r_cnt;
  logic               r_sr;

  // Clearing at terminal count means the counter can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_sr  <= 1'b0;
    end else if (!vld || rd) begin
      r_cnt <= '0;
      r_sr  <= 1'b0;
    end else if (r_cnt == LP_TC) begin
      r_cnt <= '0;
      r_sr  <= 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (SR_MODE == SR_PULSE) r_sr <= 1'b0;
    end
  end

  assign soft_reset = r_sr;
endmodule

// File: rtl/router_sync_n.sv
// NUM_CH-way router synchroniser: header address latch, write-enable steering,
// full/valid flag muxing and per-channel read-timeout soft resets.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TIMER_W = 5,
  parameter int SR_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              detect_add,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);
  localparam logic [ADDR_W:0] LP_NUM_CH = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] r_addr;
  logic              r_addr_vld;
  logic              r_addr_err;
  logic              w_addr_ok;
  logic [NUM_CH-1:0] w_sel;

  assign w_addr_ok = ({1'b0, data_in} < LP_NUM_CH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_addr_vld <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= detect_add && !w_addr_ok;
      if (detect_add) begin
        r_addr_vld <= w_addr_ok;
        if (w_addr_ok) r_addr <= data_in;
      end
    end
  end

  // r_addr only ever holds an in-range channel, so the narrowing cast is lossless.
  assign w_sel     = NUM_CH'(onehot(MAX_ADDR_W'(r_addr), r_addr_vld));
  assign write_enb = w_sel & {NUM_CH{write_enb_reg}};
  assign fifo_full = |(w_sel & full);
  assign vld_out   = ~empty;
  assign addr_err  = r_addr_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_tmr
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .TIMER_W (TIMER_W),
      .SR_MODE (sr_mode_e'(SR_MODE))
    ) u_tmr (
      .clk        (clk),
      .reset      (reset),
      .vld        (vld_out[g]),
      .rd         (read_enb[g]),
      .soft_reset (soft_reset[g])
    );
  end
endmodule

// File: tb/tb_router_sync_n.sv
// Bench for router_sync_n: a 3-channel pulse-mode and a 5-channel level-mode instance
// checked against a cycle-level behavioural model plus directed expectations.
module tb_router_sync_n;
  localparam int TO = 30;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] di0; logic da0, we0; logic [2:0] rd0, fu0, em0;
  logic [2:0] wo0, vo0, sr0; logic ff0, ae0;
  logic [2:0] di1; logic da1, we1; logic [4:0] rd1, fu1, em1;
  logic [4:0] wo1, vo1, sr1; logic ff1, ae1;

  router_sync_n dut0 (
    .clk(clk), .reset(rst), .data_in(di0), .detect_add(da0), .write_enb_reg(we0),
    .read_enb(rd0), .full(fu0), .empty(em0), .write_enb(wo0), .fifo_full(ff0),
    .vld_out(vo0), .soft_reset(sr0), .addr_err(ae0));

  router_sync_n #(.NUM_CH(5), .ADDR_W(3), .TIMEOUT(TO), .TIMER_W(5), .SR_MODE(1)) dut1 (
    .clk(clk), .reset(rst), .data_in(di1), .detect_add(da1), .write_enb_reg(we1),
    .read_enb(rd1), .full(fu1), .empty(em1), .write_enb(wo1), .fifo_full(ff1),
    .vld_out(vo1), .soft_reset(sr1), .addr_err(ae1));

  int n_assert = 0;
  int n_fail   = 0;

  // Model: idle = number of consecutive valid-and-unread cycles seen so far.
  int nch [2] = '{3, 5};
  int mode[2] = '{0, 1};
  int idle[2][5];
  bit m_sr[2][5];
  int m_addr[2];
  bit m_av[2], m_err[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_addr[d] = 0; m_av[d] = 0; m_err[d] = 0;
      for (int i = 0; i < 5; i++) begin idle[d][i] = 0; m_sr[d][i] = 0; end
    end
  endtask

  task automatic get_in(input int d, output logic [4:0] em, output logic [4:0] rd,
                        output logic [4:0] fu, output bit da, output bit we, output int di);
    em = (d == 0) ? {2'b11, em0} : em1;
    rd = (d == 0) ? {2'b00, rd0} : rd1;
    fu = (d == 0) ? {2'b00, fu0} : fu1;
    da = (d == 0) ? da0 : da1;
    we = (d == 0) ? we0 : we1;
    di = (d == 0) ? int'(di0) : int'(di1);
  endtask

  task automatic model_edge();
    logic [4:0] em, rd, fu; bit da, we; int di;
    if (rst) begin model_clear(); return; end
    for (int d = 0; d < 2; d++) begin
      get_in(d, em, rd, fu, da, we, di);
      for (int i = 0; i < nch[d]; i++) begin
        if (em[i] || rd[i]) begin
          idle[d][i] = 0; m_sr[d][i] = 0;
        end else begin
          idle[d][i]++;
          if (idle[d][i] == TO) begin m_sr[d][i] = 1; idle[d][i] = 0; end
          else if (mode[d] == 0) m_sr[d][i] = 0;
        end
      end
      m_err[d] = da && (di >= nch[d]);
      if (da) begin
        m_av[d] = (di < nch[d]);
        if (di < nch[d]) m_addr[d] = di;
      end
    end
  endtask

  task automatic check_comb();
    logic [4:0] em, rd, fu; bit da, we; int di;
    logic [31:0] e_we, e_ff, e_vo, mask;
    for (int d = 0; d < 2; d++) begin
      get_in(d, em, rd, fu, da, we, di);
      mask = (32'd1 << nch[d]) - 1;
      e_we = (we && m_av[d]) ? (32'd1 << m_addr[d]) : 32'd0;
      e_ff = m_av[d] ? 32'(fu[m_addr[d]]) : 32'd0;
      e_vo = ~32'(em) & mask;
      chk($sformatf("write_enb[d%0d]", d), (d == 0) ? 32'(wo0) : 32'(wo1), e_we);
      chk($sformatf("fifo_full[d%0d]", d), (d == 0) ? 32'(ff0) : 32'(ff1), e_ff);
      chk($sformatf("vld_out[d%0d]", d),   (d == 0) ? 32'(vo0) : 32'(vo1), e_vo);
    end
  endtask

  task automatic check_reg();
    logic [31:0] e_sr;
    for (int d = 0; d < 2; d++) begin
      e_sr = '0;
      for (int i = 0; i < nch[d]; i++) e_sr[i] = m_sr[d][i];
      chk($sformatf("soft_reset[d%0d]", d), (d == 0) ? 32'(sr0) : 32'(sr1), e_sr);
      chk($sformatf("addr_err[d%0d]", d),   (d == 0) ? 32'(ae0) : 32'(ae1), 32'(m_err[d]));
    end
  endtask

  // Inputs are set at posedge+1; outputs checked before and after the next edge.
  task automatic tick();
    #1 check_comb();
    @(posedge clk);
    model_edge();
    #1 check_reg();
  endtask

  task automatic rand_in(input bit stable_empty);
    di0 = 2'($urandom_range(0, 3)); da0 = ($urandom_range(0, 3) == 0); we0 = 1'($urandom);
    fu0 = 3'($urandom);
    di1 = 3'($urandom_range(0, 7)); da1 = ($urandom_range(0, 3) == 0); we1 = 1'($urandom);
    fu1 = 5'($urandom);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        rd0[i] = ($urandom_range(0, 44) == 0);
        em0[i] = stable_empty ? em0[i] ^ ($urandom_range(0, 59) == 0) : 1'($urandom);
      end
      rd1[i] = ($urandom_range(0, 44) == 0);
      em1[i] = stable_empty ? em1[i] ^ ($urandom_range(0, 59) == 0) : 1'($urandom);
    end
  endtask

  task automatic quiet();
    da0 = 0; we0 = 0; rd0 = '0; fu0 = '0; di0 = '0; em0 = '1;
    da1 = 0; we1 = 0; rd1 = '0; fu1 = '0; di1 = '0; em1 = '1;
  endtask

  initial begin
    rst = 1'b1;
    model_clear();
    // Reset held with random inputs
    for (int k = 0; k < 4; k++) begin
      rand_in(1'b0);
      #1 chk("rst_write_enb", 32'(wo0), 32'd0);
      chk("rst_fifo_full", 32'(ff0), 32'd0);
      tick();
      chk("rst_soft_reset", 32'({sr1, sr0}), 32'd0);
      chk("rst_addr_err", 32'({ae1, ae0}), 32'd0);
    end
    quiet();
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Header to channel 2, then payload write into a full FIFO
    da0 = 1; di0 = 2'd2;
    tick();
    da0 = 0; we0 = 1; fu0 = 3'b100;
    #1 chk("we_addr2", 32'(wo0), 32'b100);
    chk("ff_addr2", 32'(ff0), 32'd1);
    tick();

    // Out-of-range header
    da0 = 1; di0 = 2'd3; we0 = 0;
    tick();
    chk("addr_err_hi", 32'(ae0), 32'd1);
    da0 = 0; we0 = 1;
    #1 chk("we_after_err", 32'(wo0), 32'd0);
    chk("ff_after_err", 32'(ff0), 32'd0);
    tick();
    chk("addr_err_lo", 32'(ae0), 32'd0);

    // Header and payload in the same cycle use the pre-edge address
    da0 = 1; di0 = 2'd0; we0 = 0;
    tick();
    da0 = 1; di0 = 2'd1; we0 = 1;
    #1 chk("we_pre_edge", 32'(wo0), 32'b001);
    tick();
    da0 = 0;
    #1 chk("we_new_addr", 32'(wo0), 32'b010);
    tick();
    quiet();
    tick();

    // Pulse-mode timeout on channel 0: pulses at edge 30 and 60
    em0 = 3'b110;
    for (int k = 1; k <= 65; k++) begin
      tick();
      chk($sformatf("sr0_ch0_k%0d", k), 32'(sr0), (k == 30 || k == 60) ? 32'd1 : 32'd0);
    end

    // Read on cycle 29 restarts channel 1's count
    em0 = 3'b101;
    for (int k = 1; k <= 62; k++) begin
      rd0 = (k == 29) ? 3'b010 : 3'b000;
      tick();
      chk($sformatf("sr0_ch1_k%0d", k), 32'(sr0), (k == 59) ? 32'b010 : 32'd0);
    end
    quiet();
    tick();

    // Level-mode timeout on channel 4 of the 5-channel instance
    em1 = 5'b01111;
    for (int k = 1; k <= 35; k++) begin
      tick();
      chk($sformatf("sr1_ch4_k%0d", k), 32'(sr1), (k >= 30) ? 32'b10000 : 32'd0);
    end
    em1 = 5'b11111;
    tick();
    chk("sr1_ch4_drop", 32'(sr1), 32'd0);

    // Reset mid-count on channel 0; count restarts from zero afterwards
    em1 = 5'b11110;
    for (int k = 0; k < 15; k++) tick();
    rst = 1'b1;
    model_clear();
    #1 chk("async_rst_sr", 32'(sr1), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk($sformatf("sr1_post_rst_k%0d", k), 32'(sr1), (k >= 30) ? 32'b00001 : 32'd0);
    end

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      rand_in(1'b1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
